// File: rtl/pll_reconfig_sched.sv
// Round-robin run-time reprogramming sequencer for the CPU (ch0) and SOC (ch1) PLLs; gate, power-cycle, lock wait, re-enable.
// Optional PLL_SEQ_STATUS_EN adds o_status with per-channel reconfiguration counters.
module pll_reconfig_sched #(
  parameter int          STABLE_CYC = 16,
  parameter int          GATE_CYC   = 4,
  parameter int          PD_CYC     = 25,
  parameter int          LOCK_CYC   = 12500,
  parameter logic [17:0] DEF_CFG0   = {1'b1, 1'b0, 3'd1, 5'd1, 8'd40},
  parameter logic [17:0] DEF_CFG1   = {1'b1, 1'b0, 3'd1, 5'd1, 8'd32}
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [17:0] i_cfg_ch0,
  input  logic [17:0] i_cfg_ch1,
  output logic [15:0] o_pll_m,
  output logic [9:0]  o_pll_n,
  output logic [5:0]  o_pll_od,
  output logic [1:0]  o_pll_bp,
  output logic [1:0]  o_pll_oe,
  output logic [1:0]  o_pll_pd,
  output logic [1:0]  o_hold_rst,
  output logic        o_busy
`ifdef PLL_SEQ_STATUS_EN
  ,
  output logic [15:0] o_status
`endif
);

  typedef struct packed {
    logic       oe;
    logic       bp;
    logic [2:0] od;
    logic [4:0] n;
    logic [7:0] m;
  } cfg_t;

  typedef enum logic [2:0] {
    S_IDLE, S_GATE, S_PWRDN, S_LOCK, S_ENABLE, S_RELEASE
  } state_t;

  localparam int MAX_A   = (GATE_CYC > PD_CYC) ? GATE_CYC : PD_CYC;
  localparam int CNT_MAX = (MAX_A > LOCK_CYC) ? MAX_A : LOCK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(STABLE_CYC + 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ch, r_rr_next, r_busy;
  cfg_t             r_snap;
  logic [1:0]       r_pend, w_pend_nxt;
  logic [1:0]       r_oe, r_pd, r_hold;
  cfg_t             r_applied [2];
  cfg_t             r_last    [2];
  cfg_t             r_deb     [2];
  logic [SW-1:0]    r_stab    [2];
  cfg_t             w_cfg     [2];
  logic [1:0]       w_sat;
  logic             w_sel, w_cnt_zero;

  assign w_cfg[0]   = cfg_t'(i_cfg_ch0);
  assign w_cfg[1]   = cfg_t'(i_cfg_ch1);
  assign w_sat[0]   = (r_stab[0] == SW'(STABLE_CYC));
  assign w_sat[1]   = (r_stab[1] == SW'(STABLE_CYC));
  assign w_cnt_zero = (r_cnt == '0);
  assign w_sel      = (r_pend == 2'b11) ? r_rr_next : r_pend[1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (r_pend != 2'b00) w_state_nxt = S_GATE;
      S_GATE:    if (w_cnt_zero) w_state_nxt = S_PWRDN;
      S_PWRDN:   if (w_cnt_zero) w_state_nxt = S_LOCK;
      S_LOCK:    if (w_cnt_zero) w_state_nxt = S_ENABLE;
      S_ENABLE:  if (w_cnt_zero) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // A channel edited after its snapshot was taken keeps its pending bit so it is served again.
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_state == S_RELEASE && r_snap == r_deb[r_ch]) w_pend_nxt[r_ch] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (w_sat[i] && r_last[i] != r_applied[i]) w_pend_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ch         <= 1'b0;
      r_rr_next    <= 1'b0;
      r_busy       <= 1'b0;
      r_snap       <= '0;
      r_pend       <= 2'b11;
      r_oe         <= 2'b00;
      r_pd         <= 2'b11;
      r_hold       <= 2'b11;
      r_applied[0] <= cfg_t'(DEF_CFG0);
      r_applied[1] <= cfg_t'(DEF_CFG1);
      r_last[0]    <= cfg_t'(DEF_CFG0);
      r_last[1]    <= cfg_t'(DEF_CFG1);
      r_deb[0]     <= cfg_t'(DEF_CFG0);
      r_deb[1]     <= cfg_t'(DEF_CFG1);
      r_stab[0]    <= '0;
      r_stab[1]    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) || (r_state == S_RELEASE && w_pend_nxt != 2'b00);
      for (int i = 0; i < 2; i++) begin
        r_last[i] <= w_cfg[i];
        if (w_cfg[i] != r_last[i]) r_stab[i] <= '0;
        else if (!w_sat[i]) r_stab[i] <= r_stab[i] + SW'(1);
        if (w_sat[i]) r_deb[i] <= r_last[i];
      end
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          S_GATE: begin
            r_ch         <= w_sel;
            r_snap       <= r_deb[w_sel];
            r_oe[w_sel]   <= 1'b0;
            r_hold[w_sel] <= 1'b1;
            r_cnt        <= CNT_W'(GATE_CYC - 1);
          end
          S_PWRDN: begin
            r_pd[r_ch]      <= 1'b1;
            r_applied[r_ch] <= r_snap;
            r_cnt           <= CNT_W'(PD_CYC - 1);
          end
          S_LOCK: begin
            r_pd[r_ch] <= 1'b0;
            r_cnt      <= r_snap.bp ? '0 : CNT_W'(LOCK_CYC - 1);
          end
          S_ENABLE: begin
            r_oe[r_ch] <= r_snap.oe;
            r_cnt      <= CNT_W'(GATE_CYC - 1);
          end
          S_RELEASE: r_hold[r_ch] <= 1'b0;
          default:   r_rr_next <= ~r_ch;
        endcase
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_pll_m    = {r_applied[1].m,  r_applied[0].m};
  assign o_pll_n    = {r_applied[1].n,  r_applied[0].n};
  assign o_pll_od   = {r_applied[1].od, r_applied[0].od};
  assign o_pll_bp   = {r_applied[1].bp, r_applied[0].bp};
  assign o_pll_oe   = r_oe;
  assign o_pll_pd   = r_pd;
  assign o_hold_rst = r_hold;
  assign o_busy     = r_busy;

`ifdef PLL_SEQ_STATUS_EN
  logic [7:0] r_recfg_cnt0, r_recfg_cnt1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_recfg_cnt0 <= 8'd0;
      r_recfg_cnt1 <= 8'd0;
    end else if (r_state == S_RELEASE) begin
      if (r_ch) r_recfg_cnt1 <= r_recfg_cnt1 + 8'd1;
      else      r_recfg_cnt0 <= r_recfg_cnt0 + 8'd1;
    end
  end

  assign o_status = {r_recfg_cnt1, r_recfg_cnt0};
`endif

endmodule
